// File: rtl/cpu_pkg.sv
// Shared fetch-side types and constants.
// Imported by the instruction-memory responder and its response buffer.
package cpu_pkg;
    localparam int XLEN = 32;
    localparam int DEPTH_DEF = 256;
    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] addr;
        logic            fault;
    } fetch_resp_t;
endpackage

// File: rtl/fetch_resp_fifo.sv
// Two-entry in-order buffer of fetch responses.
// Flush and reset both empty it and rewind the pointers.
module fetch_resp_fifo
    import cpu_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        push,
    input  logic        pop,
    input  logic        flush,
    input  fetch_resp_t din,
    output fetch_resp_t dout,
    output logic [1:0]  count
);
    fetch_resp_t ent [2];
    logic        wptr;
    logic        rptr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= 2'd0;
            wptr  <= 1'b0;
            rptr  <= 1'b0;
        end else if (flush) begin
            count <= 2'd0;
            wptr  <= 1'b0;
            rptr  <= 1'b0;
        end else begin
            if (push) wptr <= ~wptr;
            if (pop)  rptr <= ~rptr;
            count <= count + {1'b0, push} - {1'b0, pop};
        end
    end

    // Payload is not reset; the top masks it whenever count is zero.
    always_ff @(posedge clk) begin
        if (push && !flush) ent[wptr] <= din;
    end

    assign dout = ent[rptr];
endmodule

// File: rtl/imem_fetch_responder.sv
// Instruction memory answering fetch requests with one cycle of latency.
// Holds the program array, the fault check and the request/response handshake.
module imem_fetch_responder
    import cpu_pkg::fetch_resp_t;
#(
    parameter int          DEPTH     = cpu_pkg::DEPTH_DEF,
    parameter int          ADDR_W    = 8,
    parameter logic [31:0] NOP_INSTR = cpu_pkg::NOP_INSTR
) (
    input  logic              im_clk,
    input  logic              im_rst_n,
    input  logic              im_req_valid,
    output logic              im_req_ready,
    input  logic [31:0]       im_req_addr,
    input  logic              im_flush,
    output logic              im_resp_valid,
    input  logic              im_resp_ready,
    output logic [31:0]       im_resp_instr,
    output logic [31:0]       im_resp_addr,
    output logic              im_resp_fault,
    input  logic              im_load_en,
    input  logic [ADDR_W-1:0] im_load_addr,
    input  logic [31:0]       im_load_data
);
    logic [31:0] mem [DEPTH];
    logic [1:0]  count;
    logic        push;
    logic        pop;
    logic        fault;
    fetch_resp_t din;
    fetch_resp_t head;

    always_ff @(posedge im_clk) begin
        if (im_load_en) mem[im_load_addr] <= im_load_data;
    end

    assign fault = (im_req_addr[1:0] != 2'b00) ||
                   (im_req_addr[31:2] >= 30'(DEPTH));

    // The array is sampled before this edge's load lands: read-before-write.
    always_comb begin
        din.addr  = im_req_addr;
        din.fault = fault;
        din.instr = NOP_INSTR;
        if (!fault) din.instr = mem[im_req_addr[ADDR_W+1:2]];
    end

    assign im_req_ready  = (count < 2'd2) && !im_flush;
    assign im_resp_valid = (count != 2'd0);
    assign push = im_req_valid && im_req_ready;
    assign pop  = im_resp_valid && im_resp_ready;

    fetch_resp_fifo u_fifo (
        .clk   (im_clk),
        .rst_n (im_rst_n),
        .push  (push),
        .pop   (pop),
        .flush (im_flush),
        .din   (din),
        .dout  (head),
        .count (count)
    );

    assign im_resp_instr = im_resp_valid ? head.instr : 32'd0;
    assign im_resp_addr  = im_resp_valid ? head.addr  : 32'd0;
    assign im_resp_fault = im_resp_valid ? head.fault : 1'b0;
endmodule
